// File: rtl/vme_slave_decode.sv
// VME A24 slave front-end: strobe synchronisation, AM/GA match, device/command decode, DTACK tracking and timeout.
// Optional: define VME_TIMEOUT_BERR_EN to drive BERR_B low while a timed-out cycle waits for DS release.
module vme_slave_decode #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned STROBE_DELAY = 2,
  parameter int unsigned TIMEOUT_CYC  = 255
) (
  input  logic        FASTCLK,
  input  logic        RST,
  input  logic [4:0]  GA,
  input  logic        VME_AS_B,
  input  logic [1:0]  VME_DS_B,
  input  logic        VME_WRITE_B,
  input  logic [5:0]  VME_AM,
  input  logic [23:1] VME_ADDR,
  input  logic        DTACK_IN_B,
  output logic        STROBE,
  output logic        WRITE_B,
  output logic [15:0] DEVICE,
  output logic [9:0]  COMMAND,
  output logic        BERR_B,
  output logic [7:0]  TIMEOUT_COUNT
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_ACTIVE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_ERROR   = 3'd4,
    ST_IGNORE  = 3'd5
  } state_e;

  localparam logic [3:0] DLY_LAST = 4'(STROBE_DELAY);
  localparam logic [7:0] WD_LAST  = 8'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0]      as_sync_q, dtack_sync_q, fill_q;
  logic [SYNC_STAGES-1:0][1:0] ds_sync_q;
  logic       as_s, dtack_s, ds_act_s, sync_ok_s, match_s;
  logic [1:0] ds_s;
  logic       unused_addr_s;

  state_e      state_q, state_d;
  logic [3:0]  delay_q, delay_d;
  logic [7:0]  wd_q, wd_d;
  logic        armed_q, armed_d;
  logic        strobe_q, strobe_d;
  logic        write_q, write_d;
  logic [15:0] device_q, device_d;
  logic [9:0]  command_q, command_d;
  logic        berr_q, berr_d;
  logic [7:0]  tcount_q, tcount_d;

  // fill_q marks when the synchroniser chains hold real pin samples rather than reset values
  always_ff @(posedge FASTCLK) begin
    if (RST) begin
      as_sync_q    <= '1;
      ds_sync_q    <= '1;
      dtack_sync_q <= '1;
      fill_q       <= '0;
    end else begin
      as_sync_q    <= {as_sync_q[SYNC_STAGES-2:0], VME_AS_B};
      ds_sync_q    <= {ds_sync_q[SYNC_STAGES-2:0], VME_DS_B};
      dtack_sync_q <= {dtack_sync_q[SYNC_STAGES-2:0], DTACK_IN_B};
      fill_q       <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign as_s          = as_sync_q[SYNC_STAGES-1];
  assign ds_s          = ds_sync_q[SYNC_STAGES-1];
  assign dtack_s       = dtack_sync_q[SYNC_STAGES-1];
  assign sync_ok_s     = fill_q[SYNC_STAGES-1];
  assign ds_act_s      = (ds_s != 2'b11);
  assign match_s       = ((VME_AM == 6'h39) || (VME_AM == 6'h3D)) &&
                         (VME_ADDR[23:19] == GA) && (VME_ADDR[18:16] == 3'd0);
  assign unused_addr_s = VME_ADDR[1];

  always_ff @(posedge FASTCLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      delay_q   <= 4'd0;
      wd_q      <= 8'd0;
      armed_q   <= 1'b0;
      strobe_q  <= 1'b0;
      write_q   <= 1'b1;
      device_q  <= 16'd0;
      command_q <= 10'd0;
      berr_q    <= 1'b1;
      tcount_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      wd_q      <= wd_d;
      armed_q   <= armed_d;
      strobe_q  <= strobe_d;
      write_q   <= write_d;
      device_q  <= device_d;
      command_q <= command_d;
      berr_q    <= berr_d;
      tcount_q  <= tcount_d;
    end
  end

  // armed_q: a new cycle is only accepted after IDLE has seen a genuinely released AS
  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    wd_d    = wd_q;
    armed_d = armed_q;
    if ((state_q != ST_IDLE) && as_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          delay_d = 4'd0;
          wd_d    = 8'd0;
          if (!as_s && ds_act_s) begin
            armed_d = 1'b0;
            if (armed_q && match_s) begin
              state_d = ST_SETTLE;
            end else begin
              state_d = ST_IGNORE;
            end
          end else if (as_s && sync_ok_s) begin
            armed_d = 1'b1;
          end else begin
            armed_d = armed_q;
          end
        end
        ST_SETTLE: begin
          if (delay_q == DLY_LAST) begin
            state_d = ST_ACTIVE;
            wd_d    = 8'd0;
          end else begin
            delay_d = delay_q + 4'd1;
          end
        end
        ST_ACTIVE: begin
          if (!dtack_s) begin
            state_d = ST_RELEASE;
          end else if (wd_q == WD_LAST) begin
            state_d = ST_ERROR;
          end else begin
            wd_d = wd_q + 8'd1;
          end
        end
        ST_RELEASE, ST_ERROR: begin
          if (ds_s == 2'b11) begin
            state_d = ST_IDLE;
          end else begin
            state_d = state_q;
          end
        end
        ST_IGNORE: state_d = ST_IGNORE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Registered outputs derived from the transition about to be taken
  always_comb begin
    strobe_d  = (state_d == ST_ACTIVE) || (state_d == ST_RELEASE);
    write_d   = write_q;
    device_d  = device_q;
    command_d = command_q;
    tcount_d  = tcount_q;
    if ((state_q == ST_IDLE) && (state_d == ST_SETTLE)) begin
      device_d  = 16'd1 << VME_ADDR[15:12];
      command_d = VME_ADDR[11:2];
      write_d   = VME_WRITE_B;
    end else if (state_d == ST_IDLE) begin
      device_d  = 16'd0;
      command_d = 10'd0;
      write_d   = 1'b1;
    end else begin
      device_d  = device_q;
      command_d = command_q;
      write_d   = write_q;
    end
    if ((state_q == ST_ACTIVE) && (state_d == ST_ERROR) && (tcount_q != 8'hFF)) begin
      tcount_d = tcount_q + 8'd1;
    end else begin
      tcount_d = tcount_q;
    end
`ifdef VME_TIMEOUT_BERR_EN
    berr_d = (state_d != ST_ERROR);
`else
    berr_d = 1'b1;
`endif
  end

  assign STROBE        = strobe_q;
  assign WRITE_B       = write_q;
  assign DEVICE        = device_q;
  assign COMMAND       = command_q;
  assign BERR_B        = berr_q;
  assign TIMEOUT_COUNT = tcount_q;

endmodule
